dac_frame_rx: RTL
=================

// Module: dac_frame_rx
// PURPOSE
//  Receive side of the DAC70004-style serial write link (SCLK, SYNC_N, SDIN) in the CLK_50M domain.
//  Oversamples the async link, deserializes SYNC_N-framed words MSB-first on SCLK falling edges.
//  Presents each good word with a one-cycle valid strobe; flags and counts malformed frames.
//  Used as the DAC emulator / loopback monitor for on-board checks of the DAC write path.
// PARAMETERS
//  FRAME_BITS   32  bits per valid frame (2..32)
//  SYNC_STAGES   2  synchronizer flops on SCLK/SYNC_N/SDIN (>=2)
// PORTS
//  CLK_50M      in   1   system clock; all logic on posedge
//  RST          in   1   synchronous, active-high reset
//  RX_SCLK      in   1   serial clock, async, <= CLK_50M/8, each level >= 3 CLK_50M cycles
//  RX_SYNC_N    in   1   frame enable, async, active low
//  RX_SDIN      in   1   serial data, async, stable around SCLK falling edge
//  RX_DATA      out  FRAME_BITS  last good frame word, held until next good frame
//  RX_VALID     out  1   one-cycle pulse: RX_DATA updated
//  RX_ERR       out  1   one-cycle pulse: frame closed with bit count != FRAME_BITS
//  RX_BUSY      out  1   1 while a frame is open (state SHIFT)
//  FRAME_CNT    out  16  good frames received, wraps 0xFFFF->0
//  ERR_CNT      out  8   bad frames, saturates at 0xFF
// BEHAVIOUR
//  Reset: RX_DATA=0, RX_VALID=0, RX_ERR=0, RX_BUSY=0, FRAME_CNT=0, ERR_CNT=0,
//   bit count=0, state=ARM; sync chains load 1 (SCLK,SYNC_N idle high), SDIN chain 0.
//  Edge detect on synchronized signals vs one extra delayed copy:
//   sclk_fall = prev 1 & now 0; sync_fall / sync_rise likewise on SYNC_N.
//  FSM (3 states):
//   ARM  : wait for synchronized SYNC_N==1, then -> IDLE (no frame may start mid-burst after reset).
//   IDLE : sync_fall -> SHIFT, bit count=0, shift reg=0, RX_BUSY=1.
//   SHIFT: on sclk_fall: shift reg={shift[FRAME_BITS-2:0], sdin_s}; count+=1, saturating at FRAME_BITS+1.
//          on sync_rise: -> IDLE, RX_BUSY=0; if count==FRAME_BITS: RX_DATA<=shift, RX_VALID=1, FRAME_CNT+=1;
//          else RX_ERR=1, ERR_CNT+=1 (sat); RX_DATA unchanged.
//  Simultaneous sclk_fall and sync_rise in SHIFT: bit is shifted and counted first, then frame judged with
//   updated count/data (i.e. that bit belongs to the frame).
//  SCLK falls while IDLE/ARM: ignored. SYNC_N high for whole burst: nothing captured, no pulses.
//  Extra bits (>FRAME_BITS): shift continues (keeps newest FRAME_BITS bits), count saturates -> RX_ERR on close.
//  Zero-bit frame (SYNC_N low then high, no SCLK fall): RX_ERR.
//  Latency: RX_VALID/RX_ERR asserted on the CLK_50M edge after sync_rise detected,
//   i.e. SYNC_STAGES+2 cycles after external SYNC_N rise; RX_DATA valid in the same cycle as RX_VALID.
//  RX_VALID and RX_ERR mutually exclusive; each high exactly one cycle per frame.
//  RST mid-frame: all state cleared, partial frame discarded without RX_ERR; re-enters ARM.
//  Unused state encoding -> ARM with outputs cleared (fault recovery).
// TESTING
//  T1 good frame: SYNC_N low, 32 SCLK periods (8 CLK each) shifting 0x0123_ABCD, SYNC_N high
//     -> one RX_VALID, RX_DATA=0x0123ABCD, FRAME_CNT=1, ERR_CNT=0, RX_BUSY low after close.
//  T2 short/long: frame of 31 bits then 33 bits -> two RX_ERR pulses, ERR_CNT=2,
//     RX_DATA still 0x0123ABCD, no RX_VALID.
//  T3 back-to-back: 3 frames 0xFFFFFFFF, 0x00000000, 0xA5A55A5A with 4-cycle SYNC_N-high gaps
//     -> 3 RX_VALID pulses, data in order, FRAME_CNT=3.
//  T4 reset mid-frame: RST for 1 cycle after bit 10, keep SYNC_N low, finish frame
//     -> no RX_VALID/RX_ERR; next full frame 0x80000001 -> RX_VALID, FRAME_CNT=1.
//  T5 edge coincidence: SYNC_N rise aligned with 32nd SCLK fall, data 0x00000001
//     -> RX_VALID, RX_DATA=0x00000001.
//  T6 counters: 256 short frames -> ERR_CNT=0xFF (saturated); preload 65535 good frames (force)
//     then one more -> FRAME_CNT=0.

Source files
------------

// File: rtl/dac_frame_rx_if.sv
// Serial DAC write link (SCLK, SYNC_N, SDIN) plus the receiver's word and status outputs.
interface dac_frame_rx_if #(
    parameter int FRAME_BITS = 32
);
    logic                  rx_sclk;
    logic                  rx_sync_n;
    logic                  rx_sdin;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_err;
    logic                  rx_busy;
    logic [15:0]           frame_cnt;
    logic [7:0]            err_cnt;

    modport master (
        output rx_sclk, rx_sync_n, rx_sdin,
        input  rx_data, rx_valid, rx_err, rx_busy, frame_cnt, err_cnt
    );

    modport slave (
        input  rx_sclk, rx_sync_n, rx_sdin,
        output rx_data, rx_valid, rx_err, rx_busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/dac_frame_rx.sv
// Oversampling receiver for SYNC_N-framed, MSB-first serial DAC words; flags and counts bad frames.
// RX_VALID/RX_ERR pulse SYNC_STAGES+2 cycles after SYNC_N rises; no backpressure, words are never stalled.
module dac_frame_rx #(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic          i_clk_50m,
    input  logic          i_rst,
    dac_frame_rx_if.slave io_link
);
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_sync_sync, r_sdin_sync;
    logic                   r_sclk_d, r_sync_d, r_sdin_d;
    logic                   r_sclk_fall, r_sync_fall, r_sync_rise;
    logic                   w_sclk_s, w_sync_s, w_sdin_s;

    state_t                 r_state, w_state_nxt;
    logic [AW-1:0]          r_arm_cnt, w_arm_nxt;
    logic [FRAME_BITS-1:0]  r_shift, w_shift_nxt, w_shift_upd;
    logic [CW-1:0]          r_cnt, w_cnt_nxt, w_cnt_upd;
    logic [FRAME_BITS-1:0]  r_data, w_data_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_err, w_err_nxt;
    logic [15:0]            r_frame_cnt, w_frame_cnt_nxt;
    logic [7:0]             r_err_cnt, w_err_cnt_nxt;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_sync_s = r_sync_sync[SYNC_STAGES-1];
    assign w_sdin_s = r_sdin_sync[SYNC_STAGES-1];

    // Edge pulses are registered so the FSM sees data and framing events on the same cycle
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_sclk_sync <= '1;
            r_sync_sync <= '1;
            r_sdin_sync <= '0;
            r_sclk_d    <= 1'b1;
            r_sync_d    <= 1'b1;
            r_sdin_d    <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_sync_fall <= 1'b0;
            r_sync_rise <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_link.rx_sclk};
            r_sync_sync <= {r_sync_sync[SYNC_STAGES-2:0], io_link.rx_sync_n};
            r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], io_link.rx_sdin};
            r_sclk_d    <= w_sclk_s;
            r_sync_d    <= w_sync_s;
            r_sdin_d    <= w_sdin_s;
            r_sclk_fall <= r_sclk_d & ~w_sclk_s;
            r_sync_fall <= r_sync_d & ~w_sync_s;
            r_sync_rise <= ~r_sync_d & w_sync_s;
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_state     <= ST_ARM;
            r_arm_cnt   <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_arm_cnt   <= w_arm_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_arm_nxt       = r_arm_cnt;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_err_cnt_nxt   = r_err_cnt;
        w_shift_upd     = r_shift;
        w_cnt_upd       = r_cnt;

        case (r_state)
            // The synchronizers reset to idle-high, so wait for them to flush before trusting SYNC_N
            ST_ARM: begin
                if (r_arm_cnt != ARM_LAST) begin
                    w_arm_nxt = r_arm_cnt + AW'(1);
                end else if (w_sync_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (r_sync_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_sclk_fall) begin
                    w_shift_upd = {r_shift[FRAME_BITS-2:0], r_sdin_d};
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_upd = r_cnt + CW'(1);
                    end
                end
                w_shift_nxt = w_shift_upd;
                w_cnt_nxt   = w_cnt_upd;
                // A bit clocked on the closing cycle still belongs to this frame
                if (r_sync_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (w_cnt_upd == CNT_FULL) begin
                        w_data_nxt      = w_shift_upd;
                        w_valid_nxt     = 1'b1;
                        w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                            w_err_cnt_nxt = r_err_cnt + 8'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ARM;
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign io_link.rx_data   = r_data;
    assign io_link.rx_valid  = r_valid;
    assign io_link.rx_err    = r_err;
    assign io_link.rx_busy   = (r_state == ST_SHIFT);
    assign io_link.frame_cnt = r_frame_cnt;
    assign io_link.err_cnt   = r_err_cnt;
endmodule
